// File: rtl/demux64_4_reg.sv
// One-to-four demultiplexer with a one-entry register per lane and a
// saturating count of accepted input words.
module demux64_4_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] data_in,
  input  logic [1:0]  sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] data_out_1,
  output logic [63:0] data_out_2,
  output logic [63:0] data_out_3,
  output logic [63:0] data_out_4,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [15:0] accept_count
);

  // Handshake: a word moves on any rising edge where valid and ready are both
  // high. Ready never looks at valid. A lane can take a new word in the same
  // cycle its current word drains, so a streaming lane has no bubbles.

  logic [63:0] data_q [4];
  logic [3:0]  full_q;
  logic [3:0]  full_d;
  logic [3:0]  load_vec;
  logic [3:0]  drain_vec;
  logic        in_xfer;

  always_comb begin
    in_ready  = ~full_q[sel] | out_ready[sel];
    in_xfer   = in_valid & in_ready;
    load_vec  = 4'b0000;
    if (in_xfer) load_vec[sel] = 1'b1;
    drain_vec = full_q & out_ready;
    // A same-lane load wins over the drain so the lane stays full.
    full_d    = (full_q & ~drain_vec) | load_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) full_q <= 4'b0000;
    else        full_q <= full_d;
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)           data_q[k] <= 64'd0;
      else if (load_vec[k]) data_q[k] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                accept_count <= 16'd0;
    else if (in_xfer && accept_count != 16'hFFFF) accept_count <= accept_count + 16'd1;
  end

  always_comb begin
    out_valid  = full_q;
    data_out_1 = data_q[0];
    data_out_2 = data_q[1];
    data_out_3 = data_q[2];
    data_out_4 = data_q[3];
  end

endmodule

// File: tb/tb_demux64_4_reg.sv
// Directed bench for demux64_4_reg: routing, backpressure, lane independence,
// stability, idle input, asynchronous reset and count saturation.
module tb_demux64_4_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] data_in;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_out_1, data_out_2, data_out_3, data_out_4;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] accept_count;

  int checks = 0;
  int errors = 0;

  demux64_4_reg dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4),
    .out_valid(out_valid), .out_ready(out_ready),
    .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; sel = 2'd0; data_in = 64'd0; out_ready = 4'b0000;
    #2;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got %h want 0", out_valid); end
    checks++; if (accept_count !== 16'd0) begin errors++; $display("FAIL rst_count got %h want 0", accept_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++;
    if ({data_out_1, data_out_2, data_out_3, data_out_4} !== 256'd0) begin
      errors++; $display("FAIL rst_data got %h %h %h %h want 0", data_out_1, data_out_2, data_out_3, data_out_4);
    end
    step(); step();
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_routing();
    logic [63:0] vals [4];
    vals[0] = 64'd1; vals[1] = 64'd10; vals[2] = 64'd100; vals[3] = 64'd1000;
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel = 2'(i); data_in = vals[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready lane %0d got %b want 1", i + 1, in_ready); end
      step();
    end
    in_valid = 1'b0;
    checks++; if (data_out_1 !== 64'd1) begin errors++; $display("FAIL route_d1 got %0d want 1", data_out_1); end
    checks++; if (data_out_2 !== 64'd10) begin errors++; $display("FAIL route_d2 got %0d want 10", data_out_2); end
    checks++; if (data_out_3 !== 64'd100) begin errors++; $display("FAIL route_d3 got %0d want 100", data_out_3); end
    checks++; if (data_out_4 !== 64'd1000) begin errors++; $display("FAIL route_d4 got %0d want 1000", data_out_4); end
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL route_valid got %b want 1111", out_valid); end
    checks++; if (accept_count !== 16'd4) begin errors++; $display("FAIL route_count got %0d want 4", accept_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b0000; in_valid = 1'b1; sel = 2'b10; data_in = 64'h333;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked got %b want 0", in_ready); end
    step();
    checks++; if (data_out_3 !== 64'd100) begin errors++; $display("FAIL bp_hold got %h want 64", data_out_3); end
    checks++; if (accept_count !== 16'd4) begin errors++; $display("FAIL bp_count_hold got %0d want 4", accept_count); end
    out_ready = 4'b0100;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++; if (data_out_3 !== 64'h333) begin errors++; $display("FAIL bp_new_word got %h want 333", data_out_3); end
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL bp_no_bubble got %b want 1111", out_valid); end
    checks++; if (accept_count !== 16'd5) begin errors++; $display("FAIL bp_count got %0d want 5", accept_count); end
  endtask

  task automatic test_diff_lanes();
    out_ready = 4'b1111; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL dl_drain_all got %b want 0000", out_valid); end
    out_ready = 4'b0000; in_valid = 1'b1; sel = 2'b00; data_in = 64'h11;
    step();
    out_ready = 4'b0001; sel = 2'b01; data_in = 64'hDEAD_BEEF;
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL dl_valid got %b want 0010", out_valid); end
    checks++; if (data_out_2 !== 64'hDEAD_BEEF) begin errors++; $display("FAIL dl_d2 got %h want deadbeef", data_out_2); end
    checks++; if (data_out_1 !== 64'h11) begin errors++; $display("FAIL dl_d1_kept got %h want 11", data_out_1); end
    checks++; if (accept_count !== 16'd7) begin errors++; $display("FAIL dl_count got %0d want 7", accept_count); end
  endtask

  task automatic test_stability();
    logic [63:0] exp_lane;
    out_ready = 4'b0000; in_valid = 1'b1; sel = 2'b11; data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    out_ready = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      sel = 2'(i % 3); data_in = 64'hA0 + 64'(i);
      step();
      checks++; if (data_out_4 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL stab_d4 cyc %0d got %h", i, data_out_4); end
      checks++; if (out_valid[3] !== 1'b1) begin errors++; $display("FAIL stab_v4 cyc %0d got %b want 1", i, out_valid[3]); end
      exp_lane = 64'hA0 + 64'(i);
      case (i % 3)
        0: begin checks++; if (data_out_1 !== exp_lane) begin errors++; $display("FAIL stab_wr cyc %0d got %h want %h", i, data_out_1, exp_lane); end end
        1: begin checks++; if (data_out_2 !== exp_lane) begin errors++; $display("FAIL stab_wr cyc %0d got %h want %h", i, data_out_2, exp_lane); end end
        default: begin checks++; if (data_out_3 !== exp_lane) begin errors++; $display("FAIL stab_wr cyc %0d got %h want %h", i, data_out_3, exp_lane); end end
      endcase
    end
    checks++; if (accept_count !== 16'd13) begin errors++; $display("FAIL stab_count got %0d want 13", accept_count); end
  endtask

  task automatic test_idle_input();
    out_ready = 4'b0000; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i); data_in = 64'h5A5A_0000 + 64'(i);
      step();
    end
    checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL idle_valid got %b want 1010", out_valid); end
    checks++; if (data_out_1 !== 64'hA3) begin errors++; $display("FAIL idle_d1 got %h want a3", data_out_1); end
    checks++; if (data_out_2 !== 64'hA4) begin errors++; $display("FAIL idle_d2 got %h want a4", data_out_2); end
    checks++; if (data_out_3 !== 64'hA2) begin errors++; $display("FAIL idle_d3 got %h want a2", data_out_3); end
    checks++; if (accept_count !== 16'd13) begin errors++; $display("FAIL idle_count got %0d want 13", accept_count); end
    sel = 2'b11; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready_indep got %b want 0", in_ready); end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b1111; in_valid = 1'b0;
    step();
    out_ready = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); data_in = 64'h1111 * 64'(i + 1);
      step();
    end
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL rm_full got %b want 1111", out_valid); end
    out_ready = 4'b0001; sel = 2'b00; data_in = 64'h5555;
    #3 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rm_valid got %b want 0", out_valid); end
    checks++; if (accept_count !== 16'd0) begin errors++; $display("FAIL rm_count got %0d want 0", accept_count); end
    checks++;
    if ({data_out_1, data_out_2, data_out_3, data_out_4} !== 256'd0) begin
      errors++; $display("FAIL rm_data got %h %h %h %h want 0", data_out_1, data_out_2, data_out_3, data_out_4);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 4'b0000 || data_out_1 !== 64'd0) begin errors++; $display("FAIL rm_edge_ignored got %b %h want 0 0", out_valid, data_out_1); end
    #2 reset = 1'b1;
    out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL rm_resume_valid got %b want 0001", out_valid); end
    checks++; if (data_out_1 !== 64'h5555) begin errors++; $display("FAIL rm_resume_d1 got %h want 5555", data_out_1); end
    checks++; if (accept_count !== 16'd1) begin errors++; $display("FAIL rm_resume_count got %0d want 1", accept_count); end
  endtask

  task automatic test_saturation();
    out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 65533; i++) begin
      sel = 2'(i); data_in = 64'(i);
      step();
    end
    checks++; if (accept_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", accept_count); end
    sel = 2'b01; data_in = 64'h7777;
    step();
    checks++; if (accept_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", accept_count); end
    for (int i = 0; i < 5; i++) begin
      sel = 2'(i); data_in = 64'hC0 + 64'(i);
      step();
    end
    checks++; if (accept_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", accept_count); end
    checks++; if (data_out_1 !== 64'hC4) begin errors++; $display("FAIL sat_last_word got %h want c4", data_out_1); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL sat_drained got %b want 0000", out_valid); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_diff_lanes();
    test_stability();
    test_idle_input();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
